// File: rtl/ntt_batch_sched.sv
// Batch sequencer for one ntt_core: runs host_num_ntt back-to-back transforms over
// ap_ctrl_hs, checks per-stream beat counts and flags faults. Optional: NTT_BATCH_PERF_CNT_EN.
module ntt_batch_sched #(
    parameter int BEATS_PER_NTT = 128,
    parameter int CNT_W         = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             host_start,
    input  logic [CNT_W-1:0] host_num_ntt,
    output logic             host_busy,
    output logic             host_done,
    output logic             host_err,
    output logic [CNT_W-1:0] ntt_done_cnt,
    output logic             core_ap_start,
    input  logic             core_ap_done,
    input  logic             core_ap_idle,
    input  logic             core_ap_ready,
    input  logic [3:0]       core_ostreams_write
`ifdef NTT_BATCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_cycles
`endif
);

    localparam int BW = $clog2(BEATS_PER_NTT + 1);
    localparam logic [BW-1:0] BEATS_FULL = BW'(BEATS_PER_NTT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] num_lat;
    logic [BW-1:0]    beat_cnt [4];
    logic             done_pend;
    logic             zero_batch;
    logic             ran_once;
    logic             accept;
    logic             last_ntt;
    logic             count_en;
    logic             beat_over;
    logic             beat_short;
    logic             fault;

    assign accept   = (state == S_IDLE) && host_start;
    assign last_ntt = ((ntt_done_cnt + CNT_W'(1)) == num_lat);
    // Beats are counted in LAUNCH as well so a zero-latency core loses none.
    assign count_en = (state == S_LAUNCH) || (state == S_RUN);

    always_comb begin
        beat_over  = 1'b0;
        beat_short = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (count_en && core_ostreams_write[k] && (beat_cnt[k] == BEATS_FULL))
                beat_over = 1'b1;
            if (beat_cnt[k] != BEATS_FULL)
                beat_short = 1'b1;
        end
    end

    // A done together with ready is the zero-latency case, not a fault.
    assign fault = beat_over
                 || ((state == S_CHECK) && beat_short)
                 || (core_ap_done && (state == S_IDLE))
                 || (core_ap_done && (state == S_LAUNCH) && !core_ap_ready)
                 || ((state == S_IDLE) && ran_once && !core_ap_idle);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (host_start)
                    state_nxt = (host_num_ntt == '0) ? S_FINISH : S_LAUNCH;
            end
            S_LAUNCH: begin
                if (core_ap_ready)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                if (core_ap_done || done_pend)
                    state_nxt = S_CHECK;
            end
            S_CHECK:  state_nxt = last_ntt ? S_FINISH : S_LAUNCH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            core_ap_start <= 1'b0;
            host_busy     <= 1'b0;
            host_done     <= 1'b0;
            host_err      <= 1'b0;
            ntt_done_cnt  <= '0;
            num_lat       <= '0;
            done_pend     <= 1'b0;
            zero_batch    <= 1'b0;
            ran_once      <= 1'b0;
        end else begin
            core_ap_start <= (state_nxt == S_LAUNCH);
            // Normal batches pulse done entering FINISH; an empty batch pulses one cycle later.
            host_done     <= ((state == S_CHECK) && last_ntt) || ((state == S_FINISH) && zero_batch);

            if (accept)
                host_busy <= 1'b1;
            else if (state == S_FINISH)
                host_busy <= 1'b0;

            if (accept)
                host_err <= 1'b0;
            else if (fault)
                host_err <= 1'b1;

            if (accept) begin
                ntt_done_cnt <= '0;
                num_lat      <= host_num_ntt;
                zero_batch   <= (host_num_ntt == '0);
            end else if (state == S_CHECK) begin
                ntt_done_cnt <= ntt_done_cnt + CNT_W'(1);
            end

            if (state == S_LAUNCH)
                done_pend <= core_ap_ready && core_ap_done;
            else if (state == S_CHECK)
                done_pend <= 1'b0;

            if (state == S_FINISH)
                ran_once <= 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!ap_rst_n || accept || (state == S_CHECK))
                beat_cnt[k] <= '0;
            else if (count_en && core_ostreams_write[k] && (beat_cnt[k] != BEATS_FULL))
                beat_cnt[k] <= beat_cnt[k] + BW'(1);
        end
    end

`ifdef NTT_BATCH_PERF_CNT_EN
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || accept)
            perf_cycles <= '0;
        else if (host_busy && (perf_cycles != '1))
            perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ntt_batch_sched.sv
// Directed bench for ntt_batch_sched: a scripted core model drives the ap_ctrl_hs
// handshake and output-stream strobes; expected values are hand-derived per step.
module tb_ntt_batch_sched;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        host_start;
    logic [15:0] host_num_ntt;
    logic        host_busy;
    logic        host_done;
    logic        host_err;
    logic [15:0] ntt_done_cnt;
    logic        core_ap_start;
    logic        core_ap_done;
    logic        core_ap_idle;
    logic        core_ap_ready;
    logic [3:0]  core_ostreams_write;
`ifdef NTT_BATCH_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    int checks      = 0;
    int failures    = 0;
    int hs_count    = 0;
    int done_pulses = 0;
    int start_high  = 0;
    int cyc         = 0;
    int done_cyc    = 0;

    ntt_batch_sched #(.BEATS_PER_NTT(128), .CNT_W(16)) dut (
        .ap_clk              (ap_clk),
        .ap_rst_n            (ap_rst_n),
        .host_start          (host_start),
        .host_num_ntt        (host_num_ntt),
        .host_busy           (host_busy),
        .host_done           (host_done),
        .host_err            (host_err),
        .ntt_done_cnt        (ntt_done_cnt),
        .core_ap_start       (core_ap_start),
        .core_ap_done        (core_ap_done),
        .core_ap_idle        (core_ap_idle),
        .core_ap_ready       (core_ap_ready),
        .core_ostreams_write (core_ostreams_write)
`ifdef NTT_BATCH_PERF_CNT_EN
        ,
        .perf_cycles         (perf_cycles)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Event counters sample the cycle that just ended, cycle index = cyc before increment.
    always @(posedge ap_clk) begin
        if (host_done) begin
            done_pulses++;
            done_cyc = cyc;
        end
        if (core_ap_start)
            start_high++;
        cyc++;
    end

    task automatic tick();
        @(negedge ap_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_batch(input logic [15:0] n);
        host_start   = 1'b1;
        host_num_ntt = n;
        tick();
        host_start = 1'b0;
        check("accept_busy", host_busy, 1'b1);
        check("accept_err_clr", host_err, 1'b0);
        check("accept_cnt_clr", ntt_done_cnt, 16'd0);
        check("accept_ap_start", core_ap_start, 1'b1);
    endtask

    // Returns in the first RUN cycle: ready two cycles after ap_start is seen.
    task automatic handshake();
        int n = 0;
        while (core_ap_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ap_start_seen", core_ap_start, 1'b1);
        tick();
        tick();
        core_ap_ready = 1'b1;
        check("ap_start_held", core_ap_start, 1'b1);
        tick();
        core_ap_ready = 1'b0;
        core_ap_idle  = 1'b0;
        check("ap_start_drop", core_ap_start, 1'b0);
        hs_count++;
    endtask

    task automatic do_transform(input int b0, input int b1, input int b2, input int b3,
                                input int gap, input bit last, input logic exp_err,
                                input int exp_cnt, input bit poke);
        int len;
        handshake();
        len = b0;
        if (b1 > len) len = b1;
        if (b2 > len) len = b2;
        if (b3 > len) len = b3;
        for (int i = 0; i < len; i++) begin
            core_ostreams_write[0] = (i < b0);
            core_ostreams_write[1] = (i < b1);
            core_ostreams_write[2] = (i < b2);
            core_ostreams_write[3] = (i < b3);
            core_ap_done = (gap == 0) && (i == len - 1);
            host_start   = poke && (i == 4);
            if (host_start) host_num_ntt = 16'd5;
            if (poke && i == 5) begin
                check("poke_busy", host_busy, 1'b1);
                check("poke_cnt", ntt_done_cnt, 16'(exp_cnt - 1));
                check("poke_ap_start", core_ap_start, 1'b0);
            end
            tick();
        end
        core_ostreams_write = 4'b0;
        core_ap_done = 1'b0;
        host_start   = 1'b0;
        if (gap > 0) begin
            check("err_run", host_err, exp_err);
            for (int g = 0; g < gap; g++) begin
                core_ap_done = (g == gap - 1);
                tick();
            end
            core_ap_done = 1'b0;
        end
        tick();
        core_ap_idle = 1'b1;
        check("err_after_check", host_err, exp_err);
        check("done_cnt", ntt_done_cnt, 16'(exp_cnt));
        if (last) begin
            check("done_pulse", host_done, 1'b1);
            check("busy_at_done", host_busy, 1'b1);
            tick();
            check("done_clear", host_done, 1'b0);
            check("busy_clear", host_busy, 1'b0);
        end else begin
            check("no_done_mid", host_done, 1'b0);
            check("relaunch_d2", core_ap_start, 1'b1);
        end
    endtask

    initial begin
        int dp0;
        int sc0;
        int t1;
        ap_rst_n            = 1'b0;
        host_start          = 1'b0;
        host_num_ntt        = 16'd0;
        core_ap_done        = 1'b0;
        core_ap_idle        = 1'b1;
        core_ap_ready       = 1'b0;
        core_ostreams_write = 4'b0;
        repeat (3) tick();
        check("rst_ap_start", core_ap_start, 1'b0);
        check("rst_busy", host_busy, 1'b0);
        check("rst_done", host_done, 1'b0);
        check("rst_err", host_err, 1'b0);
        check("rst_cnt", ntt_done_cnt, 16'd0);
        ap_rst_n = 1'b1;
        tick();

        // Batch of three clean transforms.
        dp0 = done_pulses;
        start_batch(16'd3);
        do_transform(128, 128, 128, 128, 0, 1'b0, 1'b0, 1, 1'b0);
        do_transform(128, 128, 128, 128, 0, 1'b0, 1'b0, 2, 1'b0);
        do_transform(128, 128, 128, 128, 0, 1'b1, 1'b0, 3, 1'b0);
        check("batch3_handshakes", hs_count, 3);
        check("batch3_one_done", done_pulses - dp0, 1);
        tick();

        // Empty batch: done at t+2, busy only at t+1, core untouched.
        sc0 = start_high;
        dp0 = done_pulses;
        host_start   = 1'b1;
        host_num_ntt = 16'd0;
        tick();
        host_start = 1'b0;
        check("zero_busy_t1", host_busy, 1'b1);
        check("zero_done_t1", host_done, 1'b0);
        check("zero_ap_start_t1", core_ap_start, 1'b0);
        tick();
        check("zero_done_t2", host_done, 1'b1);
        check("zero_busy_t2", host_busy, 1'b0);
        tick();
        check("zero_done_t3", host_done, 1'b0);
        check("zero_never_started", start_high - sc0, 0);
        check("zero_one_done", done_pulses - dp0, 1);

        // Stream 2 short by one beat in transform 1 of 2.
        start_batch(16'd2);
        do_transform(128, 128, 127, 128, 0, 1'b0, 1'b1, 1, 1'b0);
        do_transform(128, 128, 128, 128, 0, 1'b1, 1'b1, 2, 1'b0);
        tick();

        // Stream 0 overruns by one beat; done arrives three cycles later.
        start_batch(16'd1);
        do_transform(129, 128, 128, 128, 3, 1'b1, 1'b1, 1, 1'b0);
        tick();

        // Reset in the middle of transform 2 of a batch of 4.
        start_batch(16'd4);
        do_transform(128, 128, 128, 128, 0, 1'b0, 1'b0, 1, 1'b0);
        handshake();
        core_ostreams_write = 4'hf;
        repeat (3) tick();
        ap_rst_n            = 1'b0;
        core_ostreams_write = 4'b0;
        core_ap_idle        = 1'b1;
        tick();
        check("midrst_ap_start", core_ap_start, 1'b0);
        check("midrst_busy", host_busy, 1'b0);
        check("midrst_done", host_done, 1'b0);
        check("midrst_err", host_err, 1'b0);
        check("midrst_cnt", ntt_done_cnt, 16'd0);
        ap_rst_n = 1'b1;
        tick();
        start_batch(16'd1);
        do_transform(128, 128, 128, 128, 0, 1'b1, 1'b0, 1, 1'b0);
        tick();

        // host_start pulsed during RUN of transform 2 must be ignored.
        start_batch(16'd2);
        t1 = cyc;
        do_transform(128, 128, 128, 128, 0, 1'b0, 1'b0, 1, 1'b0);
        do_transform(128, 128, 128, 128, 0, 1'b1, 1'b0, 2, 1'b1);
`ifdef NTT_BATCH_PERF_CNT_EN
        check("perf_cycles", perf_cycles, 32'(done_cyc - t1 + 1));
`endif
        tick();
        check("idle_after_poke", host_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
